// File: rtl/i2c_master_rx_collector.sv
// rtl/i2c_master_rx_collector.sv - reassembles I2C read bits into bytes and queues them in a FWFT FIFO
// Also drives the per-byte NACK decision for multi-byte reads.
module i2c_master_rx_collector #(
  parameter  int FIFO_DEPTH = 4,
  parameter  int CNT_W      = 8,
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] byte_count,
  input  logic             abort,
  input  logic             bit_data,
  input  logic             bit_load,
  input  logic             byte_finish,
  output logic             nack,
  output logic             busy,
  output logic             done,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AW:0]      fifo_level,
  output logic             overflow,
  output logic             frame_err
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FINISH} state_t;

  state_t           state, state_d;
  logic [7:0]       shreg, shreg_nx;
  logic [3:0]       bit_cnt, cnt_nx;
  logic [CNT_W-1:0] bytes_left, bytes_left_d;
  logic             load_ok, extra_bit, fin, push, pop, full, wr_en, go;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (start) state_d = (byte_count != '0) ? S_COLLECT : S_FINISH;
        S_COLLECT: if (byte_finish && bytes_left == CNT_W'(1)) state_d = S_FINISH;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_FINISH);
  end

  // byte_finish judges the bit count including a bit loaded in the same cycle
  always_comb begin
    go        = (state == S_IDLE) && start;
    load_ok   = (state == S_COLLECT) && bit_load && (bit_cnt < 4'd8);
    extra_bit = (state == S_COLLECT) && bit_load && (bit_cnt == 4'd8);
    shreg_nx  = load_ok ? {shreg[6:0], bit_data} : shreg;
    cnt_nx    = bit_cnt + 4'(load_ok);
    fin       = (state == S_COLLECT) && byte_finish;
    push      = fin && (cnt_nx == 4'd8);
    if (abort)    bytes_left_d = '0;
    else if (go)  bytes_left_d = byte_count;
    else if (fin) bytes_left_d = bytes_left - CNT_W'(1);
    else          bytes_left_d = bytes_left;
  end

  always_comb begin
    out_valid = (fifo_level != '0);
    out_data  = out_valid ? mem[rd_ptr] : 8'h00;
    full      = (fifo_level == (AW+1)'(FIFO_DEPTH));
    pop       = out_valid && out_ready;
    wr_en     = push && (!full || pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      bytes_left <= '0;
      nack       <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      bytes_left <= bytes_left_d;
      nack       <= (state_d == S_COLLECT) && (bytes_left_d == CNT_W'(1));
      if (abort) begin
        shreg      <= '0;
        bit_cnt    <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_level <= '0;
      end else begin
        shreg   <= shreg_nx;
        bit_cnt <= (fin || go) ? 4'd0 : cnt_nx;
        if (go) begin
          overflow  <= 1'b0;
          frame_err <= 1'b0;
        end
        if (extra_bit || (fin && cnt_nx != 4'd8)) frame_err <= 1'b1;
        if (push && full && !pop) overflow <= 1'b1;
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (pop)   rd_ptr <= rd_ptr + AW'(1);
        fifo_level <= fifo_level + (AW+1)'(wr_en) - (AW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !abort) mem[wr_ptr] <= shreg_nx;
  end

endmodule

// File: tb/tb_i2c_master_rx_collector.sv
// tb/tb_i2c_master_rx_collector.sv - scoreboard bench for i2c_master_rx_collector
// Expected bytes are queued at stimulus time; a negedge monitor checks every pop.
module tb_i2c_master_rx_collector;

  logic       clk = 1'b0;
  logic       rst_n, start, abort, bit_data, bit_load, byte_finish, out_ready;
  logic [7:0] byte_count;
  logic       nack, busy, done, out_valid, overflow, frame_err;
  logic [7:0] out_data;
  logic [2:0] fifo_level;

  int         checks = 0;
  int         failures = 0;
  int         done_cnt = 0;
  int         d0;
  logic [7:0] sb [$];

  i2c_master_rx_collector #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_count(byte_count), .abort(abort),
    .bit_data(bit_data), .bit_load(bit_load), .byte_finish(byte_finish),
    .nack(nack), .busy(busy), .done(done), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_pop", {24'd0, out_data}, 32'hFFFF_FFFF);
      else check("pop_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [7:0] n);
    start = 1'b1; byte_count = n; tick(); start = 1'b0;
  endtask

  task automatic load_bits(input logic [15:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      bit_load = 1'b1; bit_data = v[i]; tick();
    end
    bit_load = 1'b0;
  endtask

  task automatic finish();
    byte_finish = 1'b1; tick(); byte_finish = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_bits({8'd0, b}, 8); finish();
  endtask

  task automatic send_merged(input logic [7:0] b);
    load_bits({9'd0, b[7:1]}, 7);
    bit_load = 1'b1; bit_data = b[0]; byte_finish = 1'b1; tick();
    bit_load = 1'b0; byte_finish = 1'b0;
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (fifo_level == 3'd0) break;
      tick();
    end
    check({name, "_level"}, {29'd0, fifo_level}, 32'd0);
    check({name, "_sb_empty"}, sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bit_data = 1'b0; bit_load = 1'b0;
    byte_finish = 1'b0; out_ready = 1'b0; byte_count = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {busy, nack, done, out_valid, overflow, frame_err, fifo_level, out_data},
          32'd0);
    rst_n = 1'b1;
    tick();
    check("rst_idle_busy", {31'd0, busy}, 32'd0);

    // 1: single byte, nack held for the whole byte
    d0 = done_cnt;
    do_start(8'd1);
    check("t1_nack", {31'd0, nack}, 32'd1);
    check("t1_busy", {31'd0, busy}, 32'd1);
    sb.push_back(8'hAA);
    send_byte(8'hAA);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_head", {24'd0, out_data}, 32'hAA);
    check("t1_done_now", {31'd0, done}, 32'd1);
    tick();
    check("t1_busy_after", {31'd0, busy}, 32'd0);
    check("t1_nack_after", {31'd0, nack}, 32'd0);
    tick();
    check("t1_done_pulses", done_cnt - d0, 32'd1);
    drain("t1");

    // 2: three bytes popped as they arrive; nack only on the last
    out_ready = 1'b1;
    do_start(8'd3);
    check("t2_nack_b1", {31'd0, nack}, 32'd0);
    sb.push_back(8'h5A); send_byte(8'h5A);
    check("t2_nack_b2", {31'd0, nack}, 32'd0);
    sb.push_back(8'hC3); send_byte(8'hC3);
    check("t2_nack_b3", {31'd0, nack}, 32'd1);
    sb.push_back(8'h0F); send_byte(8'h0F);
    check("t2_nack_fin", {31'd0, nack}, 32'd0);
    check("t2_flags", {30'd0, frame_err, overflow}, 32'd0);
    tick();
    drain("t2");

    // 3: six bytes into a 4-deep FIFO with no consumer
    out_ready = 1'b0;
    do_start(8'd6);
    for (int i = 1; i <= 6; i++) begin
      if (i <= 4) sb.push_back(8'(i * 8'h11));
      send_byte(8'(i * 8'h11));
    end
    check("t3_level", {29'd0, fifo_level}, 32'd4);
    check("t3_overflow", {31'd0, overflow}, 32'd1);
    check("t3_head", {24'd0, out_data}, 32'h11);
    tick();
    drain("t3");

    // 4: short byte then a 9-bit byte
    do_start(8'd2);
    check("t4_ovf_cleared", {31'd0, overflow}, 32'd0);
    load_bits(16'h0016, 5);
    finish();
    check("t4_frame_err", {31'd0, frame_err}, 32'd1);
    check("t4_nothing_pushed", {29'd0, fifo_level}, 32'd0);
    check("t4_nack", {31'd0, nack}, 32'd1);
    sb.push_back(8'h3C);
    load_bits(16'h0079, 9);
    finish();
    check("t4_frame_err_sticky", {31'd0, frame_err}, 32'd1);
    tick();
    drain("t4");

    // 5: last bit in the same cycle as byte_finish
    do_start(8'd2);
    check("t5_frame_err_cleared", {31'd0, frame_err}, 32'd0);
    sb.push_back(8'hFF); send_merged(8'hFF);
    sb.push_back(8'h81); send_merged(8'h81);
    check("t5_frame_err", {31'd0, frame_err}, 32'd0);
    tick();
    drain("t5");

    // 6: abort mid-byte with two bytes queued, then a zero-length read
    out_ready = 1'b0;
    d0 = done_cnt;
    do_start(8'd4);
    sb.push_back(8'h12); send_byte(8'h12);
    sb.push_back(8'h34); send_byte(8'h34);
    check("t6_level_pre", {29'd0, fifo_level}, 32'd2);
    load_bits(16'h0005, 3);
    abort = 1'b1; tick(); abort = 1'b0;
    sb.delete();
    check("t6_after_abort", {busy, nack, out_valid, fifo_level}, 32'd0);
    repeat (3) tick();
    check("t6_no_done", done_cnt - d0, 32'd0);
    do_start(8'd0);
    check("t6_zero_done", {31'd0, done}, 32'd1);
    tick();
    check("t6_zero_idle", {30'd0, busy, out_valid}, 32'd0);
    tick();
    check("t6_zero_pulses", done_cnt - d0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
